// File: rtl/pdm_capture.sv
// PDM microphone capture: discards start-up bits, then packs the bit stream
// LSB-first into MEM_WIDTH-bit words written round-robin into a delay buffer.
module pdm_capture #(
  parameter int MEM_WIDTH     = 16,
  parameter int MEM_DEPTH     = 65536,
  parameter int SETTLE_CYCLES = 1500
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         PDM_in,
  output logic [MEM_WIDTH-1:0]         write_data,
  output logic [$clog2(MEM_DEPTH)-1:0] write_address,
  output logic                         write_en,
  output logic                         primed
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int BW = (MEM_WIDTH < 2) ? 1 : $clog2(MEM_WIDTH);
  localparam int CW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
  localparam int CNT_END = (SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1;

  localparam logic [BW-1:0] BIDX_LAST = BW'(MEM_WIDTH - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(MEM_DEPTH - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CNT_END);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURE
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bidx_q, bidx_d;
  logic [MEM_WIDTH-1:0] shift_q, shift_d;
  logic [MEM_WIDTH-1:0] wdata_q, wdata_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic                 wen_q, wen_d;
  logic                 primed_q, primed_d;
  logic                 clr;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bidx_d   = bidx_q;
    shift_d  = shift_q;
    wdata_d  = wdata_q;
    addr_d   = addr_q;
    wen_d    = 1'b0;
    primed_d = primed_q;
    clr      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (!enable) begin
          clr = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (SETTLE_CYCLES == 0 || cnt_q == CNT_LAST) begin
            state_d = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        if (!enable) begin
          clr = 1'b1;
        end else begin
          shift_d[bidx_q] = PDM_in;
          if (bidx_q == BIDX_LAST) begin
            wdata_d = {PDM_in, shift_q[MEM_WIDTH-2:0]};
            wen_d   = 1'b1;
            bidx_d  = '0;
          end else begin
            bidx_d = bidx_q + 1'b1;
          end
          // Address advances as each write cycle ends
          if (wen_q) begin
            addr_d = addr_q + 1'b1;
            if (addr_q == ADDR_LAST) begin
              primed_d = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Dropping enable wins; a write already on the bus still completes
    if (clr) begin
      state_d  = IDLE;
      cnt_d    = '0;
      bidx_d   = '0;
      shift_d  = '0;
      addr_d   = '0;
      primed_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bidx_q   <= '0;
      shift_q  <= '0;
      wdata_q  <= '0;
      addr_q   <= '0;
      wen_q    <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bidx_q   <= bidx_d;
      shift_q  <= shift_d;
      wdata_q  <= wdata_d;
      addr_q   <= addr_d;
      wen_q    <= wen_d;
      primed_q <= primed_d;
    end
  end

  assign write_data    = wdata_q;
  assign write_address = addr_q;
  assign write_en      = wen_q;
  assign primed        = primed_q;

endmodule

// File: tb/tb_pdm_capture.sv
// Scoreboard bench for pdm_capture: sessions of random or patterned PDM bits,
// expected words queued from the bit stream and checked on each write_en.
module tb_pdm_capture;

  localparam int W  = 16;
  localparam int D  = 4;
  localparam int ST = 4;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic          PDM_in;
  logic [W-1:0]  write_data;
  logic [1:0]    write_address;
  logic          write_en;
  logic          primed;

  pdm_capture #(
    .MEM_WIDTH(W),
    .MEM_DEPTH(D),
    .SETTLE_CYCLES(ST)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .PDM_in(PDM_in),
    .write_data(write_data),
    .write_address(write_address),
    .write_en(write_en),
    .primed(primed)
  );

  typedef struct {
    int         rise;
    logic [W-1:0] data;
    logic [1:0] addr;
    logic       prm;
  } exp_t;

  exp_t q[$];
  int   ntests = 0;
  int   nfail  = 0;
  int   cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    ntests++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endfunction

  // Monitor: every write_en cycle must match the next queued word
  always @(negedge clk) begin
    if (rst_n && write_en) begin
      if (q.size() == 0) begin
        chk("spurious_write_en", 32'(write_en), 32'd0);
      end else begin
        exp_t it;
        it = q.pop_front();
        chk("write_cycle", 32'(cyc), 32'(it.rise));
        chk("write_data", 32'(write_data), 32'(it.data));
        chk("write_address", 32'(write_address), 32'(it.addr));
        chk("primed_at_write", 32'(primed), 32'(it.prm));
      end
    end
  end

  // mode 0: random bits; 1: word 0x0001 then ones; 2: ones in settle, zeros after
  task automatic session(int len, int mode, bit rst_mid);
    bit b[];
    int e;
    b = new[len];
    for (int i = 0; i < len; i++) begin
      int p;
      p = i - (ST + 1);
      case (mode)
        1:       b[i] = (p < 0) ? 1'($urandom) : ((p == 0) || (p >= W));
        2:       b[i] = (i <= ST);
        default: b[i] = 1'($urandom);
      endcase
    end
    e = cyc + 1;
    // Word k closes on capture edge e+ST+W*(k+1); write_en shows the next cycle
    for (int k = 0; ST + W * (k + 1) <= len - 1; k++) begin
      exp_t it;
      for (int j = 0; j < W; j++) it.data[j] = b[ST + 1 + W * k + j];
      it.rise = e + ST + W * (k + 1);
      it.addr = 2'(k % D);
      it.prm  = (k >= D);
      q.push_back(it);
    end
    for (int i = 0; i < len; i++) begin
      enable = 1'b1;
      PDM_in = b[i];
      @(posedge clk);
      #1;
    end
    if (!rst_mid) begin
      enable = 1'b0;
      PDM_in = 1'($urandom);
      @(posedge clk);
      #1;
      chk("idle_address", 32'(write_address), 32'd0);
      chk("idle_primed", 32'(primed), 32'd0);
      chk("idle_write_en", 32'(write_en), 32'd0);
      repeat ($urandom_range(0, 3)) begin
        PDM_in = 1'($urandom);
        @(posedge clk);
        #1;
      end
    end else begin
      @(negedge clk);
      #2;
      chk("pre_reset_write_en", 32'(write_en), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_write_en", 32'(write_en), 32'd0);
      chk("rst_write_data", 32'(write_data), 32'd0);
      chk("rst_write_address", 32'(write_address), 32'd0);
      chk("rst_primed", 32'(primed), 32'd0);
      enable = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    PDM_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_write_en", 32'(write_en), 32'd0);
    chk("reset_write_data", 32'(write_data), 32'd0);
    chk("reset_write_address", 32'(write_address), 32'd0);
    chk("reset_primed", 32'(primed), 32'd0);
    rst_n = 1'b1;
    repeat (4) begin
      PDM_in = 1'($urandom);
      @(posedge clk);
      #1;
    end
    session(ST + 1 + 2 * W + 3, 1, 1'b0);
    session(ST + 1 + W + 2, 2, 1'b0);
    session(ST + 1 + 5 * W + 4, 0, 1'b0);
    session(ST + 1 + 2 * W + 7, 0, 1'b0);
    session(ST + 1 + W + 1, 0, 1'b0);
    session(ST + 1 + 3 * W, 0, 1'b0);
    session(3, 0, 1'b0);
    for (int s = 0; s < 8; s++) begin
      session($urandom_range(1, 140), 0, 1'b0);
    end
    session(ST + 1 + 2 * W, 0, 1'b1);
    session(ST + 1 + 6 * W + 5, 0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
